// File: rtl/fb_write_bridge_pkg.sv
// rtl/fb_write_bridge_pkg.sv - framebuffer write bridge constants, FSM states and entry type
package fb_write_bridge_pkg;

  localparam logic [31:0] FB_BASE_DEF    = 32'h0000_1000;
  localparam int unsigned PIXELS_DEF     = 307200;
  localparam logic [31:0] CLR_ADDR_DEF   = 32'h0000_0FFF;
  localparam int          FIFO_DEPTH_DEF = 16;

  localparam int ADDR_W  = 19;
  localparam int PIX_W   = 24;
  localparam int ENTRY_W = ADDR_W + PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [PIX_W-1:0]  colour;
  } pix_entry_t;

  // Subtract first so windows near the top of the address space cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned pixels);
    return (addr >= base) && ((addr - base) < pixels);
  endfunction

endpackage

// File: rtl/fb_write_bridge_if.sv
// rtl/fb_write_bridge_if.sv - processor store port and pixel RAM write port bundle
interface fb_write_bridge_if;
  import fb_write_bridge_pkg::*;

  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              stall;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              busy;
  logic [15:0]       drop_cnt;

  modport master (
    input  wr_en, wr_addr, wr_data, pix_ready,
    output stall, pix_we, pix_addr, pix_data, busy, drop_cnt
  );

  modport slave (
    output wr_en, wr_addr, wr_data, pix_ready,
    input  stall, pix_we, pix_addr, pix_data, busy, drop_cnt
  );

endinterface

// File: rtl/fb_write_bridge_fifo.sv
// rtl/fb_write_bridge_fifo.sv - synchronous write-queue FIFO with registered occupancy count
module fb_write_bridge_fifo
  import fb_write_bridge_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fb_write_bridge.sv
// rtl/fb_write_bridge.sv - decodes processor stores into a pixel write queue and runs clear-screen fills
module fb_write_bridge
  import fb_write_bridge_pkg::*;
#(
  parameter logic [31:0] FB_BASE    = FB_BASE_DEF,
  parameter int unsigned PIXELS     = PIXELS_DEF,
  parameter logic [31:0] CLR_ADDR   = CLR_ADDR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  fb_write_bridge_if.master  bus
);

  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  state_t            state;
  state_t            state_nxt;
  logic              clear_pend;
  logic [PIX_W-1:0]  pend_colour;
  logic [PIX_W-1:0]  fill_colour;
  logic [ADDR_W-1:0] fill_idx;
  logic [CNT_W-1:0]  pre_cnt;
  logic [15:0]       drop_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  pix_entry_t        fifo_head;
  pix_entry_t        push_entry;

  logic win_hit;
  logic clr_hit;
  logic push;
  logic drop;
  logic pop;
  logic xfer;
  logic drain_ok;
  logic last_beat;
  logic load;
  logic unused_wr_data;

  assign win_hit = bus.wr_en && in_window(bus.wr_addr, FB_BASE, PIXELS);
  assign clr_hit = bus.wr_en && (bus.wr_addr == CLR_ADDR);
  assign push    = win_hit && !fifo_full;
  assign drop    = win_hit && fifo_full;

  assign push_entry.idx    = ADDR_W'(bus.wr_addr - FB_BASE);
  assign push_entry.colour = bus.wr_data[PIX_W-1:0];
  assign unused_wr_data    = &{1'b0, bus.wr_data[31:PIX_W]};

  fb_write_bridge_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // pre_cnt counts queued entries that were accepted before the pending clear;
  // once it reaches zero the remaining entries must wait until the fill finishes.
  assign drain_ok  = !fifo_empty && !(clear_pend && (pre_cnt == '0));
  assign last_beat = ((fifo_count == CNT_W'(1)) && !push) ||
                     (clear_pend && (pre_cnt == CNT_W'(1)));

  always_comb begin
    bus.pix_we   = 1'b0;
    bus.pix_addr = '0;
    bus.pix_data = '0;
    if (state == ST_FILL) begin
      bus.pix_we   = 1'b1;
      bus.pix_addr = fill_idx;
      bus.pix_data = fill_colour;
    end else if (drain_ok) begin
      bus.pix_we   = 1'b1;
      bus.pix_addr = fifo_head.idx;
      bus.pix_data = fifo_head.colour;
    end
  end

  assign xfer = bus.pix_we && bus.pix_ready;
  assign pop  = xfer && (state != ST_FILL);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DRAIN: begin
        if (drain_ok)
          state_nxt = (xfer && last_beat) ? ST_IDLE : ST_DRAIN;
        else if ((state == ST_IDLE) && clear_pend)
          state_nxt = ST_FILL;
        else
          state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        if (xfer && !clear_pend && !clr_hit && (fill_idx == LAST_IDX))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A new clear during a fill restarts it only on a transfer, so a stalled beat never changes.
  assign load = ((state == ST_IDLE) && (state_nxt == ST_FILL)) ||
                ((state == ST_FILL) && xfer && (clear_pend || clr_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      clear_pend  <= 1'b0;
      pend_colour <= '0;
      fill_colour <= '0;
      fill_idx    <= '0;
      pre_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (load) begin
        fill_idx    <= '0;
        fill_colour <= clr_hit ? bus.wr_data[PIX_W-1:0] : pend_colour;
        clear_pend  <= 1'b0;
      end else begin
        if ((state == ST_FILL) && xfer) fill_idx <= fill_idx + ADDR_W'(1);
        if (clr_hit) begin
          clear_pend  <= 1'b1;
          pend_colour <= bus.wr_data[PIX_W-1:0];
        end
      end

      if (clr_hit && !clear_pend)
        pre_cnt <= fifo_count - CNT_W'(pop);
      else if (clear_pend && pop && (pre_cnt != '0))
        pre_cnt <= pre_cnt - CNT_W'(1);

      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.stall    = fifo_full;
  assign bus.busy     = (state != ST_IDLE) || !fifo_empty || clear_pend;
  assign bus.drop_cnt = drop_cnt;

endmodule
